// File: rtl/key_expand_ctrl.sv
// Round-key expansion sequencer: presents the cipher key and each scheduler result in turn,
// handshaking with an external key scheduler and a downstream round-key consumer.
module key_expand_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic         abort_i,
    input  logic         rk_ack_i,
    output logic [127:0] round_key_o,
    output logic         round_key_valid_o,
    output logic [3:0]   round_num_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic         ks_start_o,
    output logic [3:0]   ks_round_o,
    output logic [127:0] ks_last_key_o,
    input  logic [127:0] ks_new_key_i,
    input  logic         ks_ready_i
);

    localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);
    localparam logic [3:0]        LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        START,
        WAIT,
        FLUSH,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [127:0]        cur_key;
    logic [127:0]        cur_key_next;
    logic [3:0]          round_cnt;
    logic [3:0]          round_cnt_next;
    logic [WCNT_W-1:0]   wait_cnt;
    logic [WCNT_W-1:0]   wait_cnt_next;
    logic                error;
    logic                error_next;
    logic                wait_expired;

    // wait_cnt holds the index of the current WAIT/FLUSH cycle, starting at 0
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_key   <= '0;
            round_cnt <= '0;
            wait_cnt  <= '0;
            error     <= 1'b0;
        end else begin
            state     <= state_next;
            cur_key   <= cur_key_next;
            round_cnt <= round_cnt_next;
            wait_cnt  <= wait_cnt_next;
            error     <= error_next;
        end
    end

    always_comb begin
        state_next     = state;
        cur_key_next   = cur_key;
        round_cnt_next = round_cnt;
        wait_cnt_next  = wait_cnt;
        error_next     = error;

        case (state)
            IDLE: begin
                if (load_i && !abort_i) begin
                    cur_key_next   = key_i;
                    round_cnt_next = '0;
                    error_next     = 1'b0;
                    state_next     = PRESENT;
                end
            end

            PRESENT: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (rk_ack_i) begin
                    if (round_cnt == LAST_ROUND) begin
                        state_next = DONE;
                    end else begin
                        round_cnt_next = round_cnt + 4'd1;
                        state_next     = START;
                    end
                end
            end

            START: begin
                wait_cnt_next = '0;
                state_next    = abort_i ? FLUSH : WAIT;
            end

            WAIT: begin
                if (abort_i) begin
                    // A result arriving with the abort is simply dropped; nothing left to flush
                    state_next    = (ks_ready_i || wait_expired) ? IDLE : FLUSH;
                    wait_cnt_next = wait_cnt + 1'b1;
                end else if (ks_ready_i) begin
                    cur_key_next = ks_new_key_i;
                    state_next   = PRESENT;
                end else if (wait_expired) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            FLUSH: begin
                if (ks_ready_i || wait_expired) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o            = (state != IDLE);
    assign round_key_valid_o = (state == PRESENT);
    assign round_key_o       = round_key_valid_o ? cur_key : '0;
    assign round_num_o       = round_cnt;
    assign done_o            = (state == DONE) && !abort_i;
    assign error_o           = error;
    // Scheduler operands come straight from held state, so they stay put through START/WAIT
    assign ks_start_o        = (state == START);
    assign ks_round_o        = round_cnt;
    assign ks_last_key_o     = cur_key;

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed bench for key_expand_ctrl with a fixed-latency key scheduler model that
// returns the FIPS-197 round keys for the 2b7e1516... cipher key.
module tb_key_expand_ctrl;

    localparam int LAT = 5;

    logic         clk;
    logic         reset;
    logic         load_i;
    logic [127:0] key_i;
    logic         abort_i;
    logic         rk_ack_i;
    logic [127:0] round_key_o;
    logic         round_key_valid_o;
    logic [3:0]   round_num_o;
    logic         busy_o;
    logic         done_o;
    logic         error_o;
    logic         ks_start_o;
    logic [3:0]   ks_round_o;
    logic [127:0] ks_last_key_o;
    logic [127:0] ks_new_key_i;
    logic         ks_ready_i;

    logic         sched_en;
    logic         man_ready;
    logic [127:0] man_key;
    logic         mdl_ready = 1'b0;
    logic [127:0] mdl_key   = '0;
    int           mdl_cnt    = 0;
    int           mdl_starts = 0;
    int           mdl_bad    = 0;
    logic [127:0] cap_key   = '0;
    logic [3:0]   cap_round = '0;

    int checks   = 0;
    int failures = 0;

    logic [127:0] rk_tab [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct packed {
        logic         ld;
        logic         ab;
        logic         ak;
        logic         rd;
        logic [127:0] nk;
        logic [8:0]   eo;   // {busy, valid, start, done, error, round_num[3:0]}
        logic [127:0] ek;
    } vec_t;

    vec_t vecs [10];

    assign ks_ready_i   = sched_en ? mdl_ready : man_ready;
    assign ks_new_key_i = sched_en ? mdl_key   : man_key;

    key_expand_ctrl #(.NUM_ROUNDS(10), .TIMEOUT(15)) dut (
        .clk               (clk),
        .reset             (reset),
        .load_i            (load_i),
        .key_i             (key_i),
        .abort_i           (abort_i),
        .rk_ack_i          (rk_ack_i),
        .round_key_o       (round_key_o),
        .round_key_valid_o (round_key_valid_o),
        .round_num_o       (round_num_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .error_o           (error_o),
        .ks_start_o        (ks_start_o),
        .ks_round_o        (ks_round_o),
        .ks_last_key_o     (ks_last_key_o),
        .ks_new_key_i      (ks_new_key_i),
        .ks_ready_i        (ks_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scheduler model: ready is sampled by the DUT LAT cycles after the START cycle
    always @(negedge clk) begin
        if (reset || !sched_en) begin
            mdl_cnt   <= 0;
            mdl_ready <= 1'b0;
        end else if (ks_start_o) begin
            mdl_starts <= mdl_starts + 1;
            if (ks_round_o == 4'd0 || ks_round_o > 4'd10)
                mdl_bad <= mdl_bad + 1;
            else if (ks_last_key_o !== rk_tab[ks_round_o - 4'd1])
                mdl_bad <= mdl_bad + 1;
            cap_key   <= ks_last_key_o;
            cap_round <= ks_round_o;
            mdl_cnt   <= LAT;
            mdl_ready <= 1'b0;
        end else if (mdl_cnt > 0) begin
            if (ks_last_key_o !== cap_key || ks_round_o !== cap_round)
                mdl_bad <= mdl_bad + 1;
            mdl_cnt   <= mdl_cnt - 1;
            mdl_ready <= (mdl_cnt == 1);
            if (mdl_cnt == 1 && cap_round <= 4'd10)
                mdl_key <= rk_tab[cap_round];
        end else begin
            mdl_ready <= 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic ab, input logic ak, input logic rd,
                                input logic [127:0] nk, input logic [8:0] eo,
                                input logic [127:0] ek);
        vec_t v;
        v.ld = ld; v.ab = ab; v.ak = ak; v.rd = rd;
        v.nk = nk; v.eo = eo; v.ek = ek;
        return v;
    endfunction

    task automatic do_load();
        @(posedge clk); #1;
        load_i = 1'b1;
        @(posedge clk); #1;
        load_i = 1'b0;
    endtask

    // Collects accepted keys from round 'first' onward until done_o, plus 3 trailing cycles
    task automatic run_keys(input string tag, input int first, output int nkeys, output int ndone);
        int n;
        int tail;
        n     = first;
        ndone = 0;
        tail  = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (round_key_valid_o && rk_ack_i) begin
                if (n > 10) begin
                    chk({tag, "_extra_key"}, 128'(n), 128'(10));
                end else begin
                    chk($sformatf("%s_key_r%0d", tag, n), round_key_o, rk_tab[n]);
                    chk($sformatf("%s_num_r%0d", tag, n), 128'(round_num_o), 128'(n));
                end
                n++;
            end
            if (done_o) ndone++;
            if (tail < 0 && ndone > 0) tail = 3;
            else if (tail > 0) tail--;
            if (tail == 0) break;
        end
        nkeys = n;
    endtask

    initial begin
        int n;
        int d;
        int found;
        int st0;
        int dn;

        reset     = 1'b1;
        load_i    = 1'b0;
        abort_i   = 1'b0;
        rk_ack_i  = 1'b0;
        key_i     = rk_tab[0];
        sched_en  = 1'b0;
        man_ready = 1'b0;
        man_key   = '0;

        vecs[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, '0,        9'b0_0_0_0_0_0000, '0);
        vecs[1] = mk(1'b0, 1'b0, 1'b0, 1'b1, '0,        9'b0_0_0_0_0_0000, '0);
        vecs[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, '0,        9'b0_0_0_0_0_0000, '0);
        vecs[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, '0,        9'b1_1_0_0_0_0000, rk_tab[0]);
        vecs[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, '0,        9'b1_1_0_0_0_0000, rk_tab[0]);
        vecs[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, '0,        9'b1_0_1_0_0_0001, '0);
        vecs[6] = mk(1'b0, 1'b0, 1'b0, 1'b1, rk_tab[1], 9'b1_0_0_0_0_0001, '0);
        vecs[7] = mk(1'b0, 1'b0, 1'b0, 1'b1, rk_tab[5], 9'b1_1_0_0_0_0001, rk_tab[1]);
        vecs[8] = mk(1'b0, 1'b1, 1'b1, 1'b0, '0,        9'b1_1_0_0_0_0001, rk_tab[1]);
        vecs[9] = mk(1'b0, 1'b0, 1'b0, 1'b0, '0,        9'b0_0_0_0_0_0001, '0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 128'({busy_o, round_key_valid_o, ks_start_o, done_o, error_o,
                              round_num_o, ks_round_o}), 128'(0));
        chk("rst_round_key", round_key_o, '0);
        chk("rst_ks_last_key", ks_last_key_o, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Cycle-by-cycle vectors with a hand-driven scheduler
        for (int i = 0; i < 10; i++) begin
            load_i    = vecs[i].ld;
            abort_i   = vecs[i].ab;
            rk_ack_i  = vecs[i].ak;
            man_ready = vecs[i].rd;
            man_key   = vecs[i].nk;
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl", i),
                128'({busy_o, round_key_valid_o, ks_start_o, done_o, error_o, round_num_o}),
                128'(vecs[i].eo));
            if (vecs[i].eo[7])
                chk($sformatf("vec%0d_key", i), round_key_o, vecs[i].ek);
            @(posedge clk); #1;
        end
        load_i = 1'b0; abort_i = 1'b0; man_ready = 1'b0; man_key = '0;

        // Full expansion, ack held high
        sched_en = 1'b1;
        rk_ack_i = 1'b1;
        st0 = mdl_starts;
        do_load();
        run_keys("fips", 0, n, d);
        chk("fips_nkeys", 128'(n), 128'(11));
        chk("fips_done", 128'(d), 128'(1));
        chk("fips_starts", 128'(mdl_starts - st0), 128'(10));

        // Backpressure in round 3
        do_load();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (round_key_valid_o && round_num_o == 4'd3) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("bp_reach_r3", 128'(found), 128'(1));
        rk_ack_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("bp_key_c%0d", i), round_key_o, rk_tab[3]);
            chk($sformatf("bp_start_c%0d", i), 128'({round_key_valid_o, ks_start_o}), 128'(2'b10));
        end
        @(posedge clk); #1;
        rk_ack_i = 1'b1;
        run_keys("bp", 3, n, d);
        chk("bp_nkeys", 128'(n), 128'(11));
        chk("bp_done", 128'(d), 128'(1));

        // Scheduler timeout, sticky error, clear on accepted load
        sched_en  = 1'b0;
        man_ready = 1'b0;
        do_load();
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (ks_start_o) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("to_start_seen", 128'(found), 128'(1));
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (!busy_o) break;
            n++;
        end
        chk("to_wait_cycles", 128'(n), 128'(15));
        chk("to_error", 128'(error_o), 128'(1));
        chk("to_idle", 128'({busy_o, round_key_valid_o}), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("to_error_sticky", 128'(error_o), 128'(1));
        load_i = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1;
        load_i = 1'b0; abort_i = 1'b0;
        chk("ldab_ignored_busy", 128'(busy_o), 128'(0));
        chk("ldab_keeps_error", 128'(error_o), 128'(1));
        do_load();
        chk("load_clears_error", 128'({error_o, busy_o, round_key_valid_o, round_num_o}),
            128'(7'b0_1_1_0000));
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("abort_present_idle", 128'({busy_o, ks_start_o, done_o}), 128'(0));

        // Abort while waiting; late result arrives in FLUSH
        sched_en = 1'b1;
        do_load();
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (ks_start_o) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("ab_start_seen", 128'(found), 128'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ab_in_wait", 128'({busy_o, ks_start_o, round_key_valid_o}), 128'(3'b100));
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        dn = 0;
        for (int i = 3; i <= 8; i++) begin
            @(negedge clk);
            if (done_o) dn++;
            chk($sformatf("ab_busy_k%0d", i), 128'({busy_o, round_key_valid_o}),
                128'({(i <= 5) ? 1'b1 : 1'b0, 1'b0}));
        end
        chk("ab_no_done", 128'(dn), 128'(0));
        do_load();
        run_keys("ab_restart", 0, n, d);
        chk("ab_restart_nkeys", 128'(n), 128'(11));
        chk("ab_restart_done", 128'(d), 128'(1));

        // Abort in the DONE cycle suppresses done_o
        do_load();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (done_o) begin found = 1; break; end
        end
        chk("ad_reach_done", 128'(found), 128'(1));
        abort_i = 1'b1;
        #1;
        chk("ad_done_suppressed", 128'(done_o), 128'(0));
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("ad_idle", 128'(busy_o), 128'(0));

        // Reset during round 6, then a clean rerun
        do_load();
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (round_num_o == 4'd6) begin found = 1; break; end
        end
        chk("rm_reach_r6", 128'(found), 128'(1));
        #1;
        reset = 1'b1;
        #1;
        chk("rm_ctrl", 128'({busy_o, round_key_valid_o, ks_start_o, done_o, error_o,
                             round_num_o, ks_round_o}), 128'(0));
        chk("rm_round_key", round_key_o, '0);
        chk("rm_ks_last_key", ks_last_key_o, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rm_idle_after", 128'({busy_o, round_num_o}), 128'(0));
        do_load();
        run_keys("rm_rerun", 0, n, d);
        chk("rm_nkeys", 128'(n), 128'(11));
        chk("rm_done", 128'(d), 128'(1));

        chk("sched_if_consistent", 128'(mdl_bad), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
